// File: rtl/otter_alu_decode_stage_if.sv
// ID->EX handshake and payload bundle for the ALU decode stage.
// master drives the instruction side, slave is the decode stage itself.
interface otter_alu_decode_stage_if #(
  parameter int unsigned XLEN = 32
);
  logic            i_valid;
  logic [31:0]     i_instr;
  logic [XLEN-1:0] i_pc;
  logic [XLEN-1:0] i_rs1_data;
  logic [XLEN-1:0] i_rs2_data;
  logic            i_stall;
  logic            i_flush;
  logic            o_ready;
  logic            o_valid;
  logic [10:0]     o_alu_fun;
  logic [XLEN-1:0] o_op_1;
  logic [XLEN-1:0] o_op_2;
  logic [4:0]      o_rd;
  logic            o_rd_we;
  logic            o_illegal;

  modport master (
    output i_valid, i_instr, i_pc, i_rs1_data, i_rs2_data, i_stall, i_flush,
    input  o_ready, o_valid, o_alu_fun, o_op_1, o_op_2, o_rd, o_rd_we, o_illegal
  );

  modport slave (
    input  i_valid, i_instr, i_pc, i_rs1_data, i_rs2_data, i_stall, i_flush,
    output o_ready, o_valid, o_alu_fun, o_op_1, o_op_2, o_rd, o_rd_we, o_illegal
  );
endinterface

// File: rtl/otter_alu_decode_stage.sv
// Registered RV32I ID->EX stage: decodes the instruction into a one-hot ALU
// function word plus both ALU operands, with valid/stall handshake and flush.
module otter_alu_decode_stage #(
  parameter int unsigned XLEN = 32
) (
  input logic                     i_clk,
  input logic                     i_rst,
  otter_alu_decode_stage_if.slave bus
);
  localparam int unsigned FUN_W = 11;
  typedef logic [FUN_W-1:0] alu_fun_t;

  localparam alu_fun_t ALU_ADD = 11'h001;
  localparam alu_fun_t ALU_SRL = 11'h020;
  localparam alu_fun_t ALU_SUB = 11'h100;
  localparam alu_fun_t ALU_SRA = 11'h200;
  localparam alu_fun_t ALU_LUI = 11'h400;

  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u;
  alu_fun_t    base_fun;

  assign instr  = bus.i_instr;
  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign imm_i  = {{(XLEN-12){instr[31]}}, instr[31:20]};
  assign imm_s  = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b  = {{(XLEN-13){instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u  = {instr[31:12], 12'b0};
  // For the non-alternate ops the one-hot bit index equals funct3.
  assign base_fun = alu_fun_t'(1) << funct3;

  alu_fun_t        dec_fun;
  logic [XLEN-1:0] dec_op1, dec_op2;
  logic            dec_we, dec_ill;

  // Combinational RV32I decode of the incoming instruction.
  always_comb begin
    dec_fun = ALU_ADD;
    dec_op1 = '0;
    dec_op2 = '0;
    dec_we  = 1'b0;
    dec_ill = 1'b0;
    case (opcode)
      OPC_OP: begin
        dec_op1 = bus.i_rs1_data;
        dec_op2 = bus.i_rs2_data;
        dec_we  = 1'b1;
        if (funct7 == F7_ZERO)                         dec_fun = base_fun;
        else if (funct7 == F7_ALT && funct3 == 3'b000) dec_fun = ALU_SUB;
        else if (funct7 == F7_ALT && funct3 == 3'b101) dec_fun = ALU_SRA;
        else                                           dec_ill = 1'b1;
      end
      OPC_OP_IMM: begin
        dec_op1 = bus.i_rs1_data;
        dec_op2 = imm_i;
        dec_we  = 1'b1;
        case (funct3)
          3'b001: begin
            if (funct7 == F7_ZERO) dec_fun = base_fun;
            else                   dec_ill = 1'b1;
          end
          3'b101: begin
            if (funct7 == F7_ZERO)     dec_fun = ALU_SRL;
            else if (funct7 == F7_ALT) dec_fun = ALU_SRA;
            else                       dec_ill = 1'b1;
          end
          default: dec_fun = base_fun;
        endcase
      end
      OPC_LUI: begin
        dec_fun = ALU_LUI;
        dec_op1 = imm_u;
        dec_we  = 1'b1;
      end
      OPC_AUIPC: begin
        dec_op1 = bus.i_pc;
        dec_op2 = imm_u;
        dec_we  = 1'b1;
      end
      OPC_JAL, OPC_JALR: begin
        dec_op1 = bus.i_pc;
        dec_op2 = XLEN'(4);
        dec_we  = 1'b1;
        if (opcode == OPC_JALR && funct3 != 3'b000) dec_ill = 1'b1;
      end
      OPC_LOAD: begin
        dec_op1 = bus.i_rs1_data;
        dec_op2 = imm_i;
        dec_we  = 1'b1;
      end
      OPC_STORE: begin
        dec_op1 = bus.i_rs1_data;
        dec_op2 = imm_s;
      end
      OPC_BRANCH: begin
        dec_op1 = bus.i_pc;
        dec_op2 = imm_b;
        if (funct3 == 3'b010 || funct3 == 3'b011) dec_ill = 1'b1;
      end
      OPC_MISC_MEM, OPC_SYSTEM: ;
      default: dec_ill = 1'b1;
    endcase
    // Illegal instructions travel down as harmless adds with zero operands.
    if (dec_ill) begin
      dec_fun = ALU_ADD;
      dec_op1 = '0;
      dec_op2 = '0;
      dec_we  = 1'b0;
    end
    if (rd == 5'd0) dec_we = 1'b0;
  end

  logic            valid_q, valid_d;
  alu_fun_t        fun_q, fun_d;
  logic [XLEN-1:0] op1_q, op1_d, op2_q, op2_d;
  logic [4:0]      rd_q, rd_d;
  logic            we_q, we_d;
  logic            ill_q, ill_d;
  logic            ready, load;

  assign ready = !valid_q || !bus.i_stall;
  assign load  = bus.i_valid && ready && !bus.i_flush;

  // Output register next-state: flush, then load, then hold, else drain.
  always_comb begin
    valid_d = valid_q;
    fun_d   = fun_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    rd_d    = rd_q;
    we_d    = we_q;
    ill_d   = ill_q;
    if (bus.i_flush) begin
      valid_d = 1'b0;
      we_d    = 1'b0;
      fun_d   = ALU_ADD;
      ill_d   = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      fun_d   = dec_fun;
      op1_d   = dec_op1;
      op2_d   = dec_op2;
      rd_d    = rd;
      we_d    = dec_we;
      ill_d   = dec_ill;
    end else if (!(valid_q && bus.i_stall)) begin
      valid_d = 1'b0;
      we_d    = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid_q <= 1'b0;
      fun_q   <= ALU_ADD;
      op1_q   <= '0;
      op2_q   <= '0;
      rd_q    <= '0;
      we_q    <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      fun_q   <= fun_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      rd_q    <= rd_d;
      we_q    <= we_d;
      ill_q   <= ill_d;
    end
  end

  assign bus.o_ready   = ready;
  assign bus.o_valid   = valid_q;
  assign bus.o_alu_fun = fun_q;
  assign bus.o_op_1    = op1_q;
  assign bus.o_op_2    = op2_q;
  assign bus.o_rd      = rd_q;
  assign bus.o_rd_we   = we_q;
  assign bus.o_illegal = ill_q;

`ifdef FORMAL
  logic chk_armed;
  always_ff @(posedge i_clk) chk_armed <= 1'b1;
  always_ff @(posedge i_clk) begin
    if (chk_armed) assert ($onehot(fun_q));
  end
`elsif SIM
  logic chk_armed;
  always_ff @(posedge i_clk) chk_armed <= 1'b1;
  always_ff @(posedge i_clk) begin
    if (chk_armed) assert ($onehot(fun_q));
  end
`endif
endmodule

// File: tb/tb_otter_alu_decode_stage.sv
// Randomized scoreboard bench for otter_alu_decode_stage against an
// instruction-level RV32I decode model.
module tb_otter_alu_decode_stage;
  typedef struct {
    logic [10:0] alu;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [4:0]  rd;
    logic        we;
    logic        ill;
  } exp_t;

  localparam int MODE_RST = 0, MODE_FLS = 1, MODE_OTH = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  otter_alu_decode_stage_if #(.XLEN(32)) bus ();

  otter_alu_decode_stage #(.XLEN(32)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  bit   chk_en = 1'b0;
  bit   mv = 1'b0, mv_next = 1'b0;
  int   mode = MODE_RST, mode_next = MODE_RST;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Instruction-level model: which ALU function, which operands, per RV32I.
  function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] pc,
                                      input logic [31:0] rs1, input logic [31:0] rs2);
    exp_t e;
    int   f3, f7, fidx;
    logic legal;
    logic signed [31:0] s;
    logic [31:0] i_imm, s_imm, b_imm, u_imm;
    s     = $signed(ins);
    f3    = int'(ins[14:12]);
    f7    = int'(ins[31:25]);
    i_imm = 32'(s >>> 20);
    s_imm = 32'((s >>> 25) <<< 5) | 32'(ins[11:7]);
    b_imm = 32'((s >>> 31) <<< 12) | (32'(ins[7]) << 11) | (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1);
    u_imm = ins & 32'hFFFF_F000;
    fidx  = 0;
    legal = 1'b1;
    e.op1 = 0; e.op2 = 0; e.we = 1'b0;
    e.rd  = ins[11:7];
    case (ins[6:0])
      7'h33: begin
        e.op1 = rs1; e.op2 = rs2; e.we = 1'b1; fidx = f3;
        if (f7 == 32 && f3 == 0) fidx = 8;
        else if (f7 == 32 && f3 == 5) fidx = 9;
        else if (f7 != 0) legal = 1'b0;
      end
      7'h13: begin
        e.op1 = rs1; e.op2 = i_imm; e.we = 1'b1; fidx = f3;
        if (f3 == 1 && f7 != 0) legal = 1'b0;
        if (f3 == 5) begin
          if (f7 == 32) fidx = 9;
          else if (f7 != 0) legal = 1'b0;
        end
      end
      7'h37: begin e.op1 = u_imm; e.we = 1'b1; fidx = 10; end
      7'h17: begin e.op1 = pc; e.op2 = u_imm; e.we = 1'b1; end
      7'h6F: begin e.op1 = pc; e.op2 = 4; e.we = 1'b1; end
      7'h67: begin e.op1 = pc; e.op2 = 4; e.we = 1'b1; legal = (f3 == 0); end
      7'h03: begin e.op1 = rs1; e.op2 = i_imm; e.we = 1'b1; end
      7'h23: begin e.op1 = rs1; e.op2 = s_imm; end
      7'h63: begin e.op1 = pc; e.op2 = b_imm; legal = !(f3 == 2 || f3 == 3); end
      7'h0F, 7'h73: ;
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      fidx = 0; e.op1 = 0; e.op2 = 0; e.we = 1'b0;
    end
    if (e.rd == 0) e.we = 1'b0;
    e.alu = 11'(1 << fidx);
    e.ill = !legal;
    return e;
  endfunction

  // One cycle of stimulus; also advances the bench's own view of o_valid.
  task automatic drive(input bit v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic [31:0] rs1, input logic [31:0] rs2,
                       input bit stall, input bit flush, input bit r);
    bit ready_m, load_m;
    @(posedge clk);
    mv   = mv_next;
    mode = mode_next;
    #1;
    bus.i_valid = v; bus.i_instr = ins; bus.i_pc = pc;
    bus.i_rs1_data = rs1; bus.i_rs2_data = rs2;
    bus.i_stall = stall; bus.i_flush = flush; rst = r;
    #1;
    ready_m = !mv || !stall;
    if (chk_en) chk("o_ready", 32'(bus.o_ready), 32'(ready_m));
    load_m = !r && !flush && v && ready_m;
    if (load_m) q.push_back(ref_decode(ins, pc, rs1, rs2));
    mv_next   = !r && !flush && (load_m || (mv && stall));
    mode_next = r ? MODE_RST : (flush ? MODE_FLS : MODE_OTH);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [6:0]  opcs[11];
    int          k;
    opcs = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h23, 7'h63, 7'h0F, 7'h73};
    r = $urandom;
    k = $urandom_range(0, 11);
    r[6:0] = (k == 11) ? 7'($urandom) : opcs[k];
    k = $urandom_range(0, 3);
    r[31:25] = (k < 2) ? 7'h00 : ((k == 2) ? 7'h20 : 7'($urandom));
    if ($urandom_range(0, 7) == 0) r[11:7] = 5'd0;
    return r;
  endfunction

  // Monitor: checks the output register against the scoreboard every cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("o_valid", 32'(bus.o_valid), 32'(mv));
      if (mv) begin
        if (q.size() == 0) begin
          chk("scoreboard_nonempty", 32'(q.size()), 32'd1);
        end else begin
          chk("alu_fun", 32'(bus.o_alu_fun), 32'(q[0].alu));
          chk("op_1", bus.o_op_1, q[0].op1);
          chk("op_2", bus.o_op_2, q[0].op2);
          chk("rd", 32'(bus.o_rd), 32'(q[0].rd));
          chk("rd_we", 32'(bus.o_rd_we), 32'(q[0].we));
          chk("illegal", 32'(bus.o_illegal), 32'(q[0].ill));
          if (rst || bus.i_flush || !bus.i_stall) void'(q.pop_front());
        end
      end else begin
        chk("idle_rd_we", 32'(bus.o_rd_we), 32'd0);
        chk("idle_alu_onehot", 32'($onehot(bus.o_alu_fun)), 32'd1);
        if (mode != MODE_OTH) begin
          chk("clr_alu_fun", 32'(bus.o_alu_fun), 32'h001);
          chk("clr_illegal", 32'(bus.o_illegal), 32'd0);
        end
        if (mode == MODE_RST) begin
          chk("rst_op_1", bus.o_op_1, 32'd0);
          chk("rst_op_2", bus.o_op_2, 32'd0);
          chk("rst_rd", 32'(bus.o_rd), 32'd0);
        end
      end
    end
  end

  initial begin
    bus.i_valid = 1'b0; bus.i_instr = '0; bus.i_pc = '0;
    bus.i_rs1_data = '0; bus.i_rs2_data = '0;
    bus.i_stall = 1'b0; bus.i_flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    chk_en = 1'b1;

    // sub x0, srai, srai with bad funct7, lui
    drive(1'b1, 32'h40208033, 32'h100, 32'd5, 32'd7, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'h4030D093, 32'h104, 32'h80000000, 32'h0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'h2030D093, 32'h108, 32'h80000000, 32'h0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'h123450B7, 32'h10C, 32'h1, 32'h2, 1'b0, 1'b0, 1'b0);
    idle(1);

    // add, then 3 stall cycles with a new instruction waiting, then release
    drive(1'b1, 32'h002081B3, 32'h200, 32'd11, 32'd22, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++)
      drive(1'b1, 32'h00A10213, 32'h204, 32'd40, 32'd0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 32'h00A10213, 32'h204, 32'd40, 32'd0, 1'b0, 1'b0, 1'b0);
    idle(1);

    // flush with a new instruction while one is held, then an illegal opcode
    drive(1'b1, 32'h002081B3, 32'h300, 32'd1, 32'd2, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'h40208133, 32'h304, 32'd3, 32'd4, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 32'h000000FF, 32'h308, 32'd9, 32'd9, 1'b0, 1'b0, 1'b0);
    idle(1);

    // reset while a stalled instruction is held
    drive(1'b1, 32'h002081B3, 32'h400, 32'd6, 32'd7, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'h00A10213, 32'h404, 32'd8, 32'd0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 32'h00A10213, 32'h404, 32'd8, 32'd0, 1'b1, 1'b0, 1'b1);
    idle(2);

    for (int n = 0; n < 600; n++)
      drive($urandom_range(0, 3) != 0, rand_instr(), $urandom & 32'hFFFF_FFFC,
            $urandom, $urandom, $urandom_range(0, 3) == 0,
            $urandom_range(0, 11) == 0, $urandom_range(0, 49) == 0);

    idle(4);
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/otter_alu_decode_stage.md
Name: otter_alu_decode_stage

Overview:
- Registered ID→EX stage that turns a raw RV32I instruction into the 11-bit one-hot ALU function word (alu_fun_t) plus the two ALU operands.
- It is the producing end of the one-hot ALU control interface, so every value it emits on o_alu_fun must be exactly one-hot, reset included.
- It sits between the register-file read and the EX stage, with a valid/stall handshake and flush support for branch redirects.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.

Ports:
- i_clk  input  1  sole clock; all state updates on rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_valid  input  1  an instruction is presented this cycle.
- i_instr  input  32  instruction word.
- i_pc  input  32  PC of i_instr.
- i_rs1_data  input  32  register-file rs1 value.
- i_rs2_data  input  32  register-file rs2 value.
- i_stall  input  1  EX stage cannot accept; hold the output register.
- i_flush  input  1  discard the held and incoming instruction.
- o_ready  output  1  stage accepts i_valid this cycle.
- o_valid  output  1  output register holds a live instruction.
- o_alu_fun  output  11  one-hot alu_fun_t; bit0 add, bit1 sll, bit2 slt, bit3 sltu, bit4 xor, bit5 srl, bit6 or, bit7 and, bit8 sub, bit9 sra, bit10 lui.
- o_op_1  output  32  ALU operand 1.
- o_op_2  output  32  ALU operand 2.
- o_rd  output  5  destination register.
- o_rd_we  output  1  register write enable.
- o_illegal  output  1  decoded instruction is illegal.

Behaviour:
- Reset values (i_rst sampled high at an edge): o_valid=0, o_alu_fun=11'h001 (add), o_op_1=0, o_op_2=0, o_rd=0, o_rd_we=0, o_illegal=0. Reset overrides stall and flush.
- o_ready = !o_valid || !i_stall. This is combinational; there is no skid buffer.
- Load condition: i_valid && o_ready && !i_flush. On load, all outputs capture the decode of i_instr and o_valid=1. Latency is 1 cycle.
- Hold condition: o_valid && i_stall && !i_flush. All outputs keep their values.
- Flush (highest priority after reset): o_valid←0, o_rd_we←0, o_alu_fun←add, o_illegal←0. The incoming instruction is dropped even if i_valid=1.
- Otherwise, when not loading and not holding: o_valid←0, o_rd_we←0. The other outputs may hold their values. o_alu_fun must stay one-hot.
- Decode, opcode i_instr[6:0]. Immediates are sign-extended per RV32I. The U-immediate is {instr[31:12],12'b0}.
  - OP (0110011): op1=rs1, op2=rs2, rd_we=1. funct3/funct7 map: 000/0000000 add, 000/0100000 sub, 001 sll, 010 slt, 011 sltu, 100 xor, 101/0000000 srl, 101/0100000 sra, 110 or, 111 and. Any other funct7 is illegal.
  - OP-IMM (0010011): op1=rs1, op2=I-imm, rd_we=1. Same map, except that sub does not exist. slli requires funct7=0. srli/srai require funct7=0000000/0100000, and others are illegal. op2[4:0] carries shamt.
  - LUI (0110111): lui, op1=U-imm, op2=0, rd_we=1.
  - AUIPC (0010111): add, op1=pc, op2=U-imm, rd_we=1.
  - JAL (1101111) and JALR (1100111): add, op1=pc, op2=4, rd_we=1. JALR requires funct3=000.
  - LOAD (0000011): add, op1=rs1, op2=I-imm, rd_we=1.
  - STORE (0100011): add, op1=rs1, op2=S-imm, rd_we=0.
  - BRANCH (1100011): add, op1=pc, op2=B-imm (target), rd_we=0. funct3 010/011 is illegal.
  - MISC-MEM (0001111) and SYSTEM (1110011): legal no-op; add, op1=0, op2=0, rd_we=0.
- Illegal (any other opcode or a rejected funct field): o_illegal=1, add, op1=op2=0, rd_we=0, o_valid=1.
- A write to rd=x0 has o_rd_we forced to 0.
- Invariant: $onehot(o_alu_fun) holds every cycle after the first edge. It is asserted under FORMAL and SIM.

Test Plan:
- Reset asserted mid-stream with o_valid=1 and i_stall=1 → the next cycle has o_valid=0, o_alu_fun=0x001, ops=0.
- i_instr=0x40208033 (sub x0,x1,x2), rs1=5, rs2=7 → 1 cycle later o_alu_fun=0x100, op1=5, op2=7, o_rd_we=0 (rd=x0).
- i_instr=0x4030D093 (srai x1,x1,3), rs1=0x80000000 → o_alu_fun=0x200, op2[4:0]=3, rd=1, rd_we=1. Changing funct7 to 0x10 → o_illegal=1, o_alu_fun=0x001.
- i_instr=0x123450B7 (lui x1,0x12345) → o_alu_fun=0x400, op1=0x12345000, op2=0.
- Load add; next cycle i_stall=1 for 3 cycles with new i_valid → o_ready=0 and outputs unchanged for 3 cycles. On stall release the new instruction appears 1 cycle later.
- i_flush=1 together with i_valid=1 while o_valid=1 → next cycle o_valid=0, o_rd_we=0, o_alu_fun=0x001. Opcode 0x7F → o_illegal=1.
